// File: rtl/branch_target_buffer_pkg.sv
// Shared LC-3b types for the fetch-stage branch target buffer.
// Holds the PC word type, the BTB index/tag/counter types, the entry
// record and the named 2-bit counter states.
package branch_target_buffer_pkg;

  typedef logic [15:0] lc3b_word;

  localparam int BTB_INDEX_BITS = 4;
  // pc[0] is never part of index or tag (word-aligned fetch).
  localparam int BTB_TAG_BITS   = 16 - BTB_INDEX_BITS - 1;

  typedef logic [BTB_INDEX_BITS-1:0] btb_index_t;
  typedef logic [BTB_TAG_BITS-1:0]   btb_tag_t;
  typedef logic [1:0]                btb_ctr_t;

  localparam btb_ctr_t CTR_STRONG_NT = 2'b00;
  localparam btb_ctr_t CTR_WEAK_NT   = 2'b01;
  localparam btb_ctr_t CTR_WEAK_T    = 2'b10;
  localparam btb_ctr_t CTR_STRONG_T  = 2'b11;

  typedef struct packed {
    logic     valid;
    btb_tag_t tag;
    lc3b_word target;
    btb_ctr_t ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating up/down counter, next-state logic only.
// Ports:
//   i_ctr - current counter value
//   i_up  - 1 = count up (taken), 0 = count down (not taken)
//   o_ctr - next counter value, held at 2'b11 / 2'b00 at the ends
module branch_target_buffer_sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  btb_ctr_t i_ctr,
  input  logic     i_up,
  output btb_ctr_t o_ctr
);

  // Saturating step in the requested direction.
  always_comb begin
    o_ctr = i_ctr;
    if (i_up) begin
      if (i_ctr != CTR_STRONG_T) begin
        o_ctr = i_ctr + 2'd1;
      end else begin
        o_ctr = CTR_STRONG_T;
      end
    end else begin
      if (i_ctr != CTR_STRONG_NT) begin
        o_ctr = i_ctr - 2'd1;
      end else begin
        o_ctr = CTR_STRONG_NT;
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the LC-3b fetch stage.
// Looks up fetch_pc combinationally against registered table state and
// learns from resolutions returned by the downstream prediction checker.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   fetch_pc           - PC being fetched this cycle
//   stall              - freezes table updates and perf counters
//   pred_taken/target  - prediction for fetch_pc (target 0 when not taken)
//   update_*           - resolution of a control instruction / false hit
//   hit_count          - saturating count of unstalled taken predictions
//   mispredict_count   - saturating count of accepted mispredict reports
// The package tag type must be at least 15-INDEX_BITS bits wide, so
// INDEX_BITS may be raised above BTB_INDEX_BITS but not lowered.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int       INDEX_BITS = BTB_INDEX_BITS,
  parameter btb_ctr_t CTR_INIT   = 2'b10
) (
  input  logic     clk,
  input  logic     reset,
  input  lc3b_word fetch_pc,
  input  logic     stall,
  output logic     pred_taken,
  output lc3b_word pred_target,
  input  logic     update_valid,
  input  lc3b_word update_pc,
  input  logic     update_taken,
  input  lc3b_word update_target,
  input  logic     update_uncond,
  input  logic     update_mispredict,
  output lc3b_word hit_count,
  output lc3b_word mispredict_count
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  btb_entry_t r_table [DEPTH];
  lc3b_word   r_hit_count;
  lc3b_word   r_mispredict_count;

  logic [INDEX_BITS-1:0] w_fetch_idx;
  btb_tag_t              w_fetch_tag;
  btb_entry_t            w_fetch_entry;
  logic                  w_fetch_taken;

  logic [INDEX_BITS-1:0] w_upd_idx;
  btb_tag_t              w_upd_tag;
  btb_entry_t            w_upd_cur;
  btb_entry_t            w_upd_next;
  logic                  w_upd_hit;
  logic                  w_upd_write;
  btb_ctr_t              w_ctr_next;

  assign w_fetch_idx   = fetch_pc[INDEX_BITS:1];
  assign w_fetch_tag   = btb_tag_t'(fetch_pc >> (INDEX_BITS + 1));
  assign w_fetch_entry = r_table[w_fetch_idx];

  assign w_upd_idx = update_pc[INDEX_BITS:1];
  assign w_upd_tag = btb_tag_t'(update_pc >> (INDEX_BITS + 1));
  assign w_upd_cur = r_table[w_upd_idx];
  assign w_upd_hit = w_upd_cur.valid && (w_upd_cur.tag == w_upd_tag);

  branch_target_buffer_sat_counter2 u_sat_counter2 (
    .i_ctr (w_upd_cur.ctr),
    .i_up  (update_taken),
    .o_ctr (w_ctr_next)
  );

  // Lookup: read straight from the table, so a same-cycle update is not seen.
  always_comb begin
    w_fetch_taken = w_fetch_entry.valid && (w_fetch_entry.tag == w_fetch_tag)
                    && w_fetch_entry.ctr[1];
    // An unknown fetch PC must never produce a taken prediction.
    if ($isunknown(fetch_pc)) begin
      w_fetch_taken = 1'b0;
    end else begin
      w_fetch_taken = w_fetch_taken;
    end
    pred_taken = w_fetch_taken;
    if (w_fetch_taken) begin
      pred_target = w_fetch_entry.target;
    end else begin
      pred_target = 16'h0000;
    end
  end

  // Next contents of the entry addressed by the update port.
  always_comb begin
    w_upd_next  = w_upd_cur;
    w_upd_write = 1'b0;
    if (w_upd_hit) begin
      w_upd_write = 1'b1;
      if (update_uncond) begin
        w_upd_next.ctr = CTR_STRONG_T;
      end else begin
        w_upd_next.ctr = w_ctr_next;
      end
      if (update_taken) begin
        w_upd_next.target = update_target;
      end else begin
        w_upd_next.target = w_upd_cur.target;
      end
      // Reaching strongly-not-taken frees the slot so a stale alias
      // (e.g. a non-branch that was predicted taken) stops matching.
      if (w_upd_next.ctr == CTR_STRONG_NT) begin
        w_upd_next.valid = 1'b0;
      end else begin
        w_upd_next.valid = 1'b1;
      end
    end else if (update_taken) begin
      w_upd_write       = 1'b1;
      w_upd_next.valid  = 1'b1;
      w_upd_next.tag    = w_upd_tag;
      w_upd_next.target = update_target;
      if (update_uncond) begin
        w_upd_next.ctr = CTR_STRONG_T;
      end else begin
        w_upd_next.ctr = CTR_INIT;
      end
    end else begin
      // Not-taken miss: nothing worth allocating.
      w_upd_write = 1'b0;
    end
  end

  // Table state and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i].valid <= 1'b0;
        r_table[i].ctr   <= CTR_STRONG_NT;
      end
      r_hit_count        <= 16'h0000;
      r_mispredict_count <= 16'h0000;
    end else if (!stall) begin
      if (w_fetch_taken && (r_hit_count != 16'hFFFF)) begin
        r_hit_count <= r_hit_count + 16'd1;
      end
      if (update_valid) begin
        if (update_mispredict && (r_mispredict_count != 16'hFFFF)) begin
          r_mispredict_count <= r_mispredict_count + 16'd1;
        end
        if (w_upd_write) begin
          r_table[w_upd_idx] <= w_upd_next;
        end
      end
    end
  end

  assign hit_count        = r_hit_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed scoreboard bench for branch_target_buffer. All test PCs map to
// index 0 with distinct tags; 16'h1000 is an idle fetch PC that never hits.
module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  logic     clk;
  logic     reset;
  lc3b_word fetch_pc;
  logic     stall;
  logic     pred_taken;
  lc3b_word pred_target;
  logic     update_valid;
  lc3b_word update_pc;
  logic     update_taken;
  lc3b_word update_target;
  logic     update_uncond;
  logic     update_mispredict;
  lc3b_word hit_count;
  lc3b_word mispredict_count;

  typedef struct {
    string    name;
    logic     taken;
    lc3b_word target;
    lc3b_word hits;
    lc3b_word misps;
  } exp_t;

  exp_t exp_q[$];
  logic chk_v;
  int   n_checks;
  int   n_fail;

  branch_target_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_pc          (fetch_pc),
    .stall             (stall),
    .pred_taken        (pred_taken),
    .pred_target       (pred_target),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_uncond     (update_uncond),
    .update_mispredict (update_mispredict),
    .hit_count         (hit_count),
    .mispredict_count  (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string nm, input string field,
                         input lc3b_word act, input lc3b_word exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
    end
  endtask

  // Monitor: whenever the driver flags a checked cycle, pop and compare.
  always @(negedge clk) begin
    if (chk_v) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        compare(e.name, "pred_taken", {15'd0, pred_taken}, {15'd0, e.taken});
        compare(e.name, "pred_target", pred_target, e.target);
        compare(e.name, "hit_count", hit_count, e.hits);
        compare(e.name, "mispredict_count", mispredict_count, e.misps);
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic cyc(input logic rst, input lc3b_word fpc, input logic stl,
                     input logic uv, input lc3b_word upc, input logic ut,
                     input lc3b_word utgt, input logic uu, input logic um,
                     input logic chk, input logic et, input lc3b_word etgt,
                     input lc3b_word eh, input lc3b_word em, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst;
    fetch_pc          = fpc;
    stall             = stl;
    update_valid      = uv;
    update_pc         = upc;
    update_taken      = ut;
    update_target     = utgt;
    update_uncond     = uu;
    update_mispredict = um;
    chk_v             = chk;
    if (chk) begin
      e.name   = nm;
      e.taken  = et;
      e.target = etgt;
      e.hits   = eh;
      e.misps  = em;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    chk_v             = 1'b0;
    reset             = 1'b1;
    fetch_pc          = 16'h1000;
    stall             = 1'b0;
    update_valid      = 1'b0;
    update_pc         = 16'h0000;
    update_taken      = 1'b0;
    update_target     = 16'h0000;
    update_uncond     = 1'b0;
    update_mispredict = 1'b0;

    //   rst   fpc       stl   uv    upc       ut    utgt      uu    um    chk   et    etgt      hits   misps
    cyc(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "rst0");
    cyc(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "rst1");
    cyc(1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0, "reset_state");
    // allocate 0x0040 -> 0x0100; same-cycle lookup sees old contents
    cyc(1'b0, 16'h0040, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0, "alloc_same_cycle");
    cyc(1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0100, 16'd0, 16'd1, "alloc_visible");
    // first not-taken: weakly taken -> weakly not taken
    cyc(1'b0, 16'h0040, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 16'd1, 16'd1, "nt1_same_cycle");
    cyc(1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd2, 16'd2, "after_nt1");
    // second not-taken: counter 00 invalidates the entry
    cyc(1'b0, 16'h1000, 1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "nt2");
    // taken update re-allocates at CTR_INIT only if the entry was invalid
    cyc(1'b0, 16'h1000, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0110, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "realloc");
    cyc(1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0110, 16'd2, 16'd2, "invalidated_then_realloc");
    // alias: 0x0060 shares index 0 with a different tag
    cyc(1'b0, 16'h1000, 1'b0, 1'b1, 16'h0060, 1'b1, 16'h0200, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "alias_update");
    cyc(1'b0, 16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd3, 16'd3, "alias_old_pc");
    cyc(1'b0, 16'h0060, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 16'd3, 16'd3, "alias_new_pc");
    // stalled update and stalled hit are both ignored
    cyc(1'b0, 16'h0060, 1'b1, 1'b1, 16'h0080, 1'b1, 16'h0300, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0200, 16'd4, 16'd3, "stall_cycle");
    cyc(1'b0, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd4, 16'd3, "stall_no_alloc");
    cyc(1'b0, 16'h0060, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 16'd4, 16'd3, "stall_entry_kept");
    // JSR: unconditional allocate strongly taken
    cyc(1'b0, 16'h00A0, 1'b0, 1'b1, 16'h00A0, 1'b1, 16'h0400, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd5, 16'd3, "jsr_same_cycle");
    cyc(1'b0, 16'h00A0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0400, 16'd5, 16'd3, "jsr_visible");
    cyc(1'b0, 16'h1000, 1'b0, 1'b1, 16'h00A0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "jsr_nt");
    cyc(1'b0, 16'h00A0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0400, 16'd6, 16'd4, "jsr_still_taken");
    // taken hit with a new target; counter 10 -> 11
    cyc(1'b0, 16'h1000, 1'b0, 1'b1, 16'h00A0, 1'b1, 16'h0500, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "retarget");
    cyc(1'b0, 16'h00A0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0500, 16'd7, 16'd5, "retarget_visible");
    // saturate at 11, then one not-taken must leave it taken
    cyc(1'b0, 16'h1000, 1'b0, 1'b1, 16'h00A0, 1'b1, 16'h0500, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "sat_up");
    cyc(1'b0, 16'h1000, 1'b0, 1'b1, 16'h00A0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "sat_nt1");
    cyc(1'b0, 16'h00A0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0500, 16'd8, 16'd5, "sat_held");
    cyc(1'b0, 16'h1000, 1'b0, 1'b1, 16'h00A0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "sat_nt2");
    cyc(1'b0, 16'h00A0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd9, 16'd5, "weak_nt");
    // reset wins over a simultaneous taken update
    cyc(1'b1, 16'h1000, 1'b0, 1'b1, 16'h0060, 1'b1, 16'h0600, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 16'd0, "reset_vs_update");
    cyc(1'b0, 16'h0060, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 16'd0, "reset_override");

    @(posedge clk);
    #1;
    chk_v        = 1'b0;
    update_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
